random_event_scheduler: RTL and testbench



---
 rtl/random_event_pkg.sv | 18 +
 rtl/lfsr_prng.sv | 28 ++
 rtl/random_event_scheduler.sv | 151 +++++++++++++++
 tb/tb_random_event_scheduler.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/random_event_pkg.sv
// random_event_pkg
//   Shared definitions for the random event scheduler: the scheduler state
//   encoding, the PRNG width and feedback taps, and the default PRNG seed.
//   No ports (package).
package random_event_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_COUNT = 2'd1,
    ST_FIRE  = 2'd2
  } sched_state_e;

  localparam int          LFSR_W            = 32;
  // Taps 32,22,2,1 expressed as a mask over bits [31],[21],[1],[0].
  localparam logic [31:0] LFSR_TAPS         = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED_DEFAULT = 32'h1234_5678;

endpackage

// File: rtl/lfsr_prng.sv
// lfsr_prng
//   Free-running Fibonacci LFSR, shifting left with the XOR of the tapped bits
//   fed into bit 0. Advances every clock while out of reset.
// Ports
//   clk    in   1      clock
//   rst_n  in   1      async active-low reset, loads SEED
//   value  out  WIDTH  current LFSR contents
module lfsr_prng
  import random_event_pkg::*;
#(
  parameter int               WIDTH = LFSR_W,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(LFSR_SEED_DEFAULT),
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED;
    end else begin
      value <= {value[WIDTH-2:0], ^(value & TAPS)};
    end
  end

endmodule

// File: rtl/random_event_scheduler.sv
// random_event_scheduler
//   Waits a pseudo-random number of cycles in [MIN_TIME, MIN_TIME+2^SPAN_LOG2-1]
//   (counting only while the game phase is in PHASE_MASK and no event is
//   active), then emits a one-cycle pulse on one enabled event channel.
//   Optional build macro: RANDOM_EVENT_NO_REPEAT_EN -- when defined, the
//   channel fired last is skipped during the channel search unless it is the
//   only enabled one.
// Ports
//   clk            in   1               clock
//   rst_n          in   1               async active-low reset
//   current_state  in   STATE_W         phase from the game FSM
//   event_active   in   1               high while any event handler runs
//   ev_enable      in   NUM_EV          per-channel enable, sampled in FIRE
//   trig           out  NUM_EV          one-hot, one-cycle trigger pulse
//   trig_id        out  clog2(NUM_EV)   index of the last fired channel
//   armed          out  1               high while counting
//
// state  | meaning
// LOAD   | draw a new target from the PRNG, clear the timer
// COUNT  | timer advances while run is high, holds otherwise
// FIRE   | pick a channel and pulse it; parks here while no channel is enabled
module random_event_scheduler
  import random_event_pkg::*;
#(
  parameter int                        NUM_EV     = 4,
  parameter int                        CNT_W      = 32,
  parameter int                        STATE_W    = 3,
  parameter logic [(1<<STATE_W)-1:0]   PHASE_MASK = 8'b0001_1010,
  parameter int unsigned               MIN_TIME   = 250_000_000,
  parameter int                        SPAN_LOG2  = 29,
  parameter logic [LFSR_W-1:0]         LFSR_SEED  = LFSR_SEED_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [STATE_W-1:0]        current_state,
  input  logic                      event_active,
  input  logic [NUM_EV-1:0]         ev_enable,
  output logic [NUM_EV-1:0]         trig,
  output logic [$clog2(NUM_EV)-1:0] trig_id,
  output logic                      armed
);

  localparam int ID_W = $clog2(NUM_EV);

  if (NUM_EV < 2 || NUM_EV > 8) begin : g_chk_num_ev
    $error("random_event_scheduler: NUM_EV must be 2..8");
  end
  if (SPAN_LOG2 < 1 || SPAN_LOG2 > LFSR_W) begin : g_chk_span
    $error("random_event_scheduler: SPAN_LOG2 out of range");
  end
  if (CNT_W < 64 &&
      (64'(MIN_TIME) + (64'd1 << SPAN_LOG2)) >= (64'd1 << CNT_W)) begin : g_chk_window
    $error("random_event_scheduler: delay window does not fit in CNT_W");
  end

  logic [LFSR_W-1:0] lfsr;
  sched_state_e      state;
  logic [CNT_W-1:0]  timer;
  logic [CNT_W-1:0]  target;
  logic              run;
  logic [ID_W-1:0]   cand;
  logic [ID_W-1:0]   pick;
  logic              found;
  logic [NUM_EV-1:0] en_eff;

  lfsr_prng #(
    .WIDTH (LFSR_W),
    .SEED  (LFSR_SEED),
    .TAPS  (LFSR_TAPS)
  ) u_prng (
    .clk   (clk),
    .rst_n (rst_n),
    .value (lfsr)
  );

  assign run  = PHASE_MASK[current_state] && !event_active;
  assign cand = ID_W'(32'(lfsr[7:0]) % NUM_EV);

`ifdef RANDOM_EVENT_NO_REPEAT_EN
  logic [NUM_EV-1:0] not_last;
  assign not_last = ev_enable & ~(NUM_EV'(1) << trig_id);
  // Fall back to the full enable set so a lone enabled channel can still repeat.
  assign en_eff   = (not_last != '0) ? not_last : ev_enable;
`else
  assign en_eff   = ev_enable;
`endif

  // Round-robin search starting at cand; first enabled channel wins.
  always_comb begin
    logic [ID_W:0] sum;
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    for (int i = 0; i < NUM_EV; i++) begin
      sum = {1'b0, cand} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(NUM_EV)) begin
        sum = sum - (ID_W+1)'(NUM_EV);
      end
      if (!found && en_eff[sum[ID_W-1:0]]) begin
        found = 1'b1;
        pick  = sum[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_LOAD;
      timer   <= '0;
      target  <= CNT_W'(MIN_TIME);
      trig    <= '0;
      trig_id <= '0;
      armed   <= 1'b0;
    end else begin
      trig <= '0;
      case (state)
        ST_LOAD: begin
          target <= CNT_W'(MIN_TIME) + CNT_W'(lfsr[SPAN_LOG2-1:0]);
          timer  <= '0;
          armed  <= 1'b1;
          state  <= ST_COUNT;
        end
        ST_COUNT: begin
          // Out of the phase mask or during an event the timer simply holds.
          if (run) begin
            if (timer != '1) begin
              timer <= timer + CNT_W'(1);
            end
            if (timer >= target) begin
              armed <= 1'b0;
              state <= ST_FIRE;
            end
          end
        end
        ST_FIRE: begin
          // run is ignored here: the decision to fire was already taken.
          if (found) begin
            trig    <= NUM_EV'(1) << pick;
            trig_id <= pick;
            state   <= ST_LOAD;
          end
        end
        default: begin
          armed <= 1'b0;
          state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_random_event_scheduler.sv
// tb_random_event_scheduler
//   Randomized scoreboard bench for random_event_scheduler with a short delay
//   window (MIN_TIME=10, SPAN_LOG2=3, NUM_EV=4). A reference model predicts
//   each pulse (cycle and channel) and queues it; a monitor compares.
module tb_random_event_scheduler;

  localparam int          NUM_EV = 4;
  localparam int          MIN_T  = 10;
  localparam int          SPAN   = 3;
  localparam logic [7:0]  MASK   = 8'b0001_1010;
  localparam logic [31:0] SEED   = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  current_state = 3'd1;
  logic        event_active = 1'b0;
  logic [3:0]  ev_enable = 4'hF;
  logic [3:0]  trig;
  logic [1:0]  trig_id;
  logic        armed;

  always #5 clk = ~clk;

  random_event_scheduler #(
    .NUM_EV    (NUM_EV),
    .MIN_TIME  (MIN_T),
    .SPAN_LOG2 (SPAN)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .current_state (current_state),
    .event_active  (event_active),
    .ev_enable     (ev_enable),
    .trig          (trig),
    .trig_id       (trig_id),
    .armed         (armed)
  );

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  function automatic void check_range(string name, longint act, longint lo, longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct {int cyc; int ch;} exp_t;
  exp_t exp_q[$];

  int          cyc;          // clock edges since reset release
  int          mode;         // 0 draw delay, 1 waiting, 2 choosing channel
  int          need;         // run-cycles still needed before the decision
  int          m_target;
  int          m_fire_T;
  int          m_last_id;
  bit          m_armed;
  logic [31:0] m_prng;

  function automatic logic [31:0] prng_next(logic [31:0] v);
    return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_prng    = SEED;
        mode      = 0;
        cyc       = 0;
        m_armed   = 1'b0;
        m_last_id = 0;
        exp_q.delete();
      end else begin
        cyc++;
        if (mode == 0) begin
          m_target = MIN_T + int'(m_prng & 32'h7);
          need     = m_target + 1;
          mode     = 1;
        end else if (mode == 1) begin
          if (MASK[current_state] && !event_active) begin
            need--;
            if (need == 0) mode = 2;
          end
        end else begin
          int         cand;
          int         ch;
          logic [3:0] en;
          cand = int'(m_prng[7:0]) % NUM_EV;
          en   = ev_enable;
`ifdef RANDOM_EVENT_NO_REPEAT_EN
          if ((en & ~(4'b0001 << m_last_id)) != 4'b0000) en = en & ~(4'b0001 << m_last_id);
`endif
          ch = -1;
          for (int i = 0; i < NUM_EV; i++) begin
            if (ch < 0 && en[(cand + i) % NUM_EV]) ch = (cand + i) % NUM_EV;
          end
          if (ch >= 0) begin
            exp_q.push_back('{cyc: cyc, ch: ch});
            m_fire_T  = m_target;
            m_last_id = ch;
            mode      = 0;
          end
        end
        m_armed = (mode == 1);
        m_prng  = prng_next(m_prng);
      end
    end
  end

  // ---------------- monitor ----------------
  int pulse_cnt = 0;
  int arm_seq   = 0;
  int arm_cyc   = 0;
  bit prev_armed = 1'b0;
  int dly_extra = -1;
  int hist[4];
  int rec_mode  = 0;
  int rec_idx   = 0;
  int rec_cyc[3];
  int rec_ch[3];
`ifdef RANDOM_EVENT_NO_REPEAT_EN
  bit have_prev = 1'b0;
  int prev_id   = 0;
`endif

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev_armed = 1'b0;
`ifdef RANDOM_EVENT_NO_REPEAT_EN
        have_prev = 1'b0;
`endif
      end else begin
        check("armed", armed, m_armed);
        if (armed && !prev_armed) begin
          arm_cyc = cyc;
          arm_seq++;
        end
        prev_armed = armed;
        if (trig != 4'b0000) begin
          pulse_cnt++;
          check("trig_onehot", $countones(trig), 1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_trig actual=%b required=none", trig);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("trig_cycle", cyc, e.cyc);
            check("trig_vec", trig, 1 << e.ch);
            check("trig_id", trig_id, e.ch);
          end
          hist[trig_id]++;
          if (dly_extra >= 0) check("trig_delay", cyc - arm_cyc, m_fire_T + 2 + dly_extra);
          if (dly_extra == 0) check_range("trig_delay_window", cyc - arm_cyc, 12, 19);
          if (rec_mode == 1 && rec_idx < 3) begin
            rec_cyc[rec_idx] = cyc;
            rec_ch[rec_idx]  = int'(trig_id);
            rec_idx++;
          end else if (rec_mode == 2 && rec_idx < 3) begin
            check("replay_cycle", cyc, rec_cyc[rec_idx]);
            check("replay_ch", trig_id, rec_ch[rec_idx]);
            rec_idx++;
          end
`ifdef RANDOM_EVENT_NO_REPEAT_EN
          if (have_prev) check("no_repeat", (int'(trig_id) != prev_id), 1);
          have_prev = 1'b1;
          prev_id   = int'(trig_id);
`endif
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          exp_t e;
          e = exp_q.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_trig actual=none required=ch%0d@%0d", e.ch, e.cyc);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pulses(int n, int budget);
    int tgt;
    int k;
    tgt = pulse_cnt + n;
    k   = 0;
    while (pulse_cnt < tgt && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (pulse_cnt < tgt) begin
      checks++;
      errors++;
      $display("FAIL wait_pulses_timeout actual=%0d required=%0d", pulse_cnt, tgt);
    end
  endtask

  task automatic wait_arm_rise(int budget);
    int a0;
    int k;
    a0 = arm_seq;
    k  = 0;
    while (arm_seq == a0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (arm_seq == a0) begin
      checks++;
      errors++;
      $display("FAIL wait_armed_timeout actual=%0d required=%0d", arm_seq, a0 + 1);
    end
  endtask

  task automatic run_random(int n, int budget);
    int         tgt;
    int         k;
    int         r;
    logic [2:0] in_mask[3];
    in_mask = '{3'd1, 3'd3, 3'd4};
    tgt = pulse_cnt + n;
    k   = 0;
    while (pulse_cnt < tgt && k < budget) begin
      @(negedge clk);
      k++;
      r = $urandom_range(0, 99);
      if (r < 3) current_state = 3'($urandom_range(0, 7));
      else if (r < 10) current_state = in_mask[$urandom_range(0, 2)];
      event_active = ($urandom_range(0, 99) < 5);
    end
    if (pulse_cnt < tgt) begin
      checks++;
      errors++;
      $display("FAIL random_run_timeout actual=%0d required=%0d", pulse_cnt, tgt);
    end
  endtask

  initial begin
    int p0;
    for (int i = 0; i < 4; i++) hist[i] = 0;

    // Reset state and first power-up sequence (recorded for the replay test).
    #1 rst_n = 1'b0;
    #3;
    check("reset_trig", trig, 0);
    check("reset_trig_id", trig_id, 0);
    check("reset_armed", armed, 0);
    step(3);
    rec_mode  = 1;
    rec_idx   = 0;
    dly_extra = 0;
    rst_n     = 1'b1;
    wait_pulses(3, 200);
    rec_mode  = 0;
    dly_extra = -1;

    // Phase outside the mask freezes the timer; resume in phase 3.
    wait_arm_rise(50);
    step(3);
    dly_extra     = 100;
    p0            = pulse_cnt;
    current_state = 3'd2;
    step(100);
    check("no_trig_masked", pulse_cnt, p0);
    check("armed_while_masked", armed, 1);
    current_state = 3'd3;
    wait_pulses(1, 100);
    dly_extra = -1;

    // event_active pause of 50 cycles.
    current_state = 3'd1;
    wait_arm_rise(50);
    step(3);
    dly_extra    = 50;
    event_active = 1'b1;
    step(50);
    event_active = 1'b0;
    wait_pulses(1, 100);
    dly_extra = -1;

    // Single enabled channel, then park in FIRE with no enables.
    ev_enable = 4'b0100;
    wait_pulses(4, 200);
    check("single_ch_trig_id", trig_id, 2);
    ev_enable = 4'b0000;
    p0 = pulse_cnt;
    step(45);
    check("parked_no_trig", pulse_cnt, p0);
    check("parked_armed", armed, 0);
    ev_enable = 4'b0001;
    @(posedge clk);
    #1;
    check("unpark_trig", trig, 4'b0001);
    step(1);

    // Long randomized run: phase/event disturbances, all channels enabled.
    ev_enable = 4'hF;
    for (int i = 0; i < 4; i++) hist[i] = 0;
    run_random(1000, 60000);
    current_state = 3'd1;
    event_active  = 1'b0;
    for (int i = 0; i < 4; i++) check_range($sformatf("hist_ch%0d", i), hist[i], 150, 350);

    // Async reset while counting, then while parked in FIRE.
    step(1);
    wait_arm_rise(100);
    step(5);
    #2 rst_n = 1'b0;
    #1;
    check("rst_count_trig", trig, 0);
    check("rst_count_armed", armed, 0);
    check("rst_count_trig_id", trig_id, 0);
    ev_enable = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    step(45);
    check("park_before_rst_armed", armed, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_fire_trig", trig, 0);
    check("rst_fire_armed", armed, 0);
    check("rst_fire_trig_id", trig_id, 0);

    // After release the pulse sequence must replay the first power-up.
    ev_enable     = 4'hF;
    current_state = 3'd1;
    event_active  = 1'b0;
    rec_mode      = 2;
    rec_idx       = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_pulses(3, 200);
    check("replay_count", rec_idx, 3);
    step(2);
    check("pending_expected", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
